rv_alu: RTL and testbench
=========================

RV_ALU -- requirements
Module: rv_alu

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: inst  input  32  RV32I instruction word in execute.
REQ-005 Port: in_a  input  32  operand A (rs1 or PC, selected upstream).
REQ-006 Port: in_b  input  32  operand B (rs2, immediate or 4, selected upstream).
REQ-007 Port: imm  output  32  decoded immediate of inst.
REQ-008 Port: result  output  32  ALU result.
REQ-009 Port: take_b  output  1  branch condition true.

Function
REQ-010 Opcode is inst[6:0], funct3 is inst[14:12], alt bit is inst[30]; shift amount is in_b[4:0].
REQ-011 imm for I-form opcodes (0010011, 0000011, 1100111, 1110011) SHALL be sign-extended inst[31:20].
REQ-012 imm for S-type (0100011) SHALL be sign-extended {inst[31:25], inst[11:7]}.
REQ-013 imm for B-type (1100011) SHALL be sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
REQ-014 imm for LUI (0110111) and AUIPC (0010111) SHALL be {inst[31:12], 12'b0}.
REQ-015 imm for JAL (1101111) SHALL be sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}; every other opcode SHALL give 0.
REQ-016 For R-type (0110011) and OP-IMM (0010011), result SHALL follow funct3:
- 000: ADD, or SUB only when R-type and inst[30]=1.
- 001: SLL.
- 010: SLT (signed).
- 011: SLTU.
- 100: XOR.
- 101: SRL, or SRA when inst[30]=1.
- 110: OR.
- 111: AND.
REQ-017 ADDI SHALL never subtract, whatever inst[30] is.
REQ-018 SLT and SLTU SHALL return 32'd1 or 32'd0.
REQ-019 For every other opcode, result SHALL be in_a + in_b, modulo 2^32, with no carry out.
REQ-020 For B-type, take_b SHALL follow funct3:
- 000: BEQ (a==b).
- 001: BNE.
- 100: BLT (signed).
- 101: BGE (signed).
- 110: BLTU.
- 111: BGEU.
- 010 and 011: 0.
REQ-021 take_b SHALL be 0 for any non-B-type opcode.
REQ-022 Without ALU_OUTREG_EN, all outputs SHALL be combinational, with zero-cycle latency, and clk/reset SHALL be unused.

Reset
REQ-023 With ALU_OUTREG_EN, a reset at a rising edge SHALL force result=0, imm=0 and take_b=0 on the next cycle, overriding the inputs.
REQ-024 Reset has no effect in combinational mode.

Configuration
REQ-025 The macro ALU_OUTREG_EN SHALL control output registering.
- Defined: imm, result and take_b are registered on clk, with 1-cycle latency.
- Undefined: the outputs are combinational per REQ-022.

Structure
REQ-026 Opcode constants (7-bit), funct3 codes and the XLEN=32 parameter SHALL live in a shared package rv_pkg.
REQ-027 Immediate decode SHALL be one sub-module, rv_imm_mux (inst in, imm out, combinational).
REQ-028 The ALU datapath and branch compare SHALL be in rv_alu.

Verification
REQ-029 SUB: inst=0x40000033, a=5, b=7 -> result=0xFFFFFFFE, take_b=0.
REQ-030 ADDI with inst[30]=1: inst=0x40008093, a=10, b=0x400 -> result=0x40A (addition, not subtraction).
REQ-031 SRA and SRL:
- SRA: inst=0x40005033, a=0x80000000, b=0x21 -> result=0xC0000000 (shift by 1).
- SRL: same a and b -> result=0x40000000.
REQ-032 Branch compares with a=0xFFFFFFFF, b=1:
- BLT (inst=0x00004063) -> take_b=1.
- BLTU (inst=0x00006063) -> take_b=0.
- BEQ with a=b=3 -> take_b=1.
REQ-033 Immediates:
- inst=0xFFF00093 -> imm=0xFFFFFFFF.
- JAL inst=0x8000006F -> imm=0xFFF00000.
- LUI inst=0x123450B7 -> imm=0x12345000.
- R-type -> imm=0.
REQ-034 With ALU_OUTREG_EN:
- ADD 2+3 -> result=5 one cycle later.
- Reset asserted alongside the same inputs -> result=0 next cycle.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I constants for the ALU slice: XLEN, opcodes and funct3 codes.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/rv_alu_if.sv
// Execute-stage bus between the operand-select logic (master) and rv_alu (slave).
interface rv_alu_if;
    import rv_pkg::*;

    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] result;
    logic            take_b;

    modport master (output inst, in_a, in_b, input imm, result, take_b);
    modport slave  (input inst, in_a, in_b, output imm, result, take_b);

endinterface

// File: rtl/rv_imm_mux.sv
// Combinational RV32I immediate decoder; unknown opcodes yield zero.
module rv_imm_mux
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0] opcode;
    assign opcode = inst_i[6:0];

    always_comb begin
        imm_o = '0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
                imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            OPC_STORE:
                imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            OPC_BRANCH:
                imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_o = {inst_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_alu.sv
// RV32I execute ALU with branch compare and immediate decode.
// Define ALU_OUTREG_EN to register imm/result/take_b (1-cycle latency, sync reset).
module rv_alu
    import rv_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    rv_alu_if.slave   alu_bus
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            alt;
    logic [4:0]      shamt;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;

    assign opcode = alu_bus.inst[6:0];
    assign funct3 = alu_bus.inst[14:12];
    assign alt    = alu_bus.inst[30];
    assign a      = alu_bus.in_a;
    assign b      = alu_bus.in_b;
    assign shamt  = b[4:0];

    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] result_d;
    logic            take_b_d;

    rv_imm_mux u_imm_mux (
        .inst_i (alu_bus.inst),
        .imm_o  (imm_d)
    );

    logic lt_s;
    logic lt_u;
    logic eq;

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;
    assign eq   = (a == b);

    // OP-IMM shares the decode, but only the register form may subtract
    always_comb begin
        result_d = a + b;
        if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
            case (funct3)
                F3_ADD:  result_d = (opcode == OPC_OP && alt) ? (a - b) : (a + b);
                F3_SLL:  result_d = a << shamt;
                F3_SLT:  result_d = {{(XLEN-1){1'b0}}, lt_s};
                F3_SLTU: result_d = {{(XLEN-1){1'b0}}, lt_u};
                F3_XOR:  result_d = a ^ b;
                F3_SR:   result_d = alt ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
                F3_OR:   result_d = a | b;
                F3_AND:  result_d = a & b;
                default: result_d = a + b;
            endcase
        end
    end

    always_comb begin
        take_b_d = 1'b0;
        if (opcode == OPC_BRANCH) begin
            case (funct3)
                F3_BEQ:  take_b_d = eq;
                F3_BNE:  take_b_d = !eq;
                F3_BLT:  take_b_d = lt_s;
                F3_BGE:  take_b_d = !lt_s;
                F3_BLTU: take_b_d = lt_u;
                F3_BGEU: take_b_d = !lt_u;
                default: take_b_d = 1'b0;
            endcase
        end
    end

`ifdef ALU_OUTREG_EN
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] result_q;
    logic            take_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            imm_q    <= '0;
            result_q <= '0;
            take_b_q <= 1'b0;
        end else begin
            imm_q    <= imm_d;
            result_q <= result_d;
            take_b_q <= take_b_d;
        end
    end

    assign alu_bus.imm    = imm_q;
    assign alu_bus.result = result_q;
    assign alu_bus.take_b = take_b_q;
`else
    // clk and reset have no function in the combinational build
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    assign alu_bus.imm    = imm_d;
    assign alu_bus.result = result_d;
    assign alu_bus.take_b = take_b_d;
`endif

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu; works with or without ALU_OUTREG_EN.
module tb_rv_alu;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    rv_alu_if bus ();

    rv_alu dut (
        .clk     (clk),
        .reset   (reset),
        .alu_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.inst = i;
        bus.in_a = a;
        bus.in_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_res;
        logic [31:0] exp_imm;
        logic        exp_tb;
        reset = 1'b1;
        apply(32'h8000_0063, 32'd3, 32'd3);
        apply(32'h8000_0063, 32'd3, 32'd3);
`ifdef ALU_OUTREG_EN
        exp_res = 32'd0; exp_imm = 32'd0; exp_tb = 1'b0;
`else
        exp_res = 32'd6; exp_imm = 32'hFFFF_F000; exp_tb = 1'b1;
`endif
        checks++;
        if (bus.result !== exp_res) begin
            failures++;
            $display("FAIL reset_result: got %h want %h", bus.result, exp_res);
        end
        checks++;
        if (bus.imm !== exp_imm) begin
            failures++;
            $display("FAIL reset_imm: got %h want %h", bus.imm, exp_imm);
        end
        checks++;
        if (bus.take_b !== exp_tb) begin
            failures++;
            $display("FAIL reset_take_b: got %b want %b", bus.take_b, exp_tb);
        end
        reset = 1'b0;
    endtask

    task automatic test_r_type();
        logic [31:0] insts [12] = '{32'h0000_0033, 32'h4000_0033, 32'h0000_1033, 32'h0000_2033,
                                    32'h0000_3033, 32'h0000_4033, 32'h0000_5033, 32'h4000_5033,
                                    32'h0000_6033, 32'h0000_7033, 32'h0000_2033, 32'h0000_3033};
        logic [31:0] va    [12] = '{32'h8000_0005, 32'h8000_0005, 32'h8000_0005, 32'h8000_0005,
                                    32'h8000_0005, 32'h8000_0005, 32'h8000_0005, 32'h8000_0005,
                                    32'h8000_0005, 32'h8000_0005, 32'd3, 32'd3};
        logic [31:0] vb    [12] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3,
                                    32'd3, 32'd3, 32'h8000_0005, 32'h8000_0005};
        logic [31:0] exp   [12] = '{32'h8000_0008, 32'h8000_0002, 32'h0000_0028, 32'd1,
                                    32'd0, 32'h8000_0006, 32'h1000_0000, 32'hF000_0000,
                                    32'h8000_0007, 32'h0000_0001, 32'd0, 32'd1};
        for (int k = 0; k < 12; k++) begin
            apply(insts[k], va[k], vb[k]);
            checks++;
            if (bus.result !== exp[k] || bus.take_b !== 1'b0 || bus.imm !== 32'd0) begin
                failures++;
                $display("FAIL r_type[%0d]: inst=%h got res=%h tb=%b imm=%h want res=%h tb=0 imm=0",
                         k, insts[k], bus.result, bus.take_b, bus.imm, exp[k]);
            end
        end
        apply(32'h4000_0033, 32'd5, 32'd7);
        checks++;
        if (bus.result !== 32'hFFFF_FFFE || bus.take_b !== 1'b0) begin
            failures++;
            $display("FAIL sub_vec: got res=%h tb=%b want res=fffffffe tb=0", bus.result, bus.take_b);
        end
        apply(32'h4000_5033, 32'h8000_0000, 32'h21);
        checks++;
        if (bus.result !== 32'hC000_0000) begin
            failures++;
            $display("FAIL sra_vec: got %h want c0000000", bus.result);
        end
        apply(32'h0000_5033, 32'h8000_0000, 32'h21);
        checks++;
        if (bus.result !== 32'h4000_0000) begin
            failures++;
            $display("FAIL srl_vec: got %h want 40000000", bus.result);
        end
    endtask

    task automatic test_op_imm();
        apply(32'h4000_8093, 32'd10, 32'h400);
        checks++;
        if (bus.result !== 32'h0000_040A || bus.imm !== 32'h0000_0400) begin
            failures++;
            $display("FAIL addi_alt: got res=%h imm=%h want res=0000040a imm=00000400", bus.result, bus.imm);
        end
        apply(32'h4010_5013, 32'h8000_0000, 32'h401);
        checks++;
        if (bus.result !== 32'hC000_0000) begin
            failures++;
            $display("FAIL srai: got %h want c0000000", bus.result);
        end
        apply(32'hFFF0_2013, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (bus.result !== 32'd1) begin
            failures++;
            $display("FAIL slti: got %h want 00000001", bus.result);
        end
    endtask

    task automatic test_other_add();
        logic [31:0] insts [4] = '{32'h1234_50B7, 32'h0000_4063, 32'h0000_2003, 32'h0000_006F};
        logic [31:0] va    [4] = '{32'd0, 32'hFFFF_FFFF, 32'h1000_0000, 32'hFFFF_FFF0};
        logic [31:0] vb    [4] = '{32'h1234_5000, 32'd1, 32'h0000_0010, 32'd4};
        logic [31:0] exp   [4] = '{32'h1234_5000, 32'd0, 32'h1000_0010, 32'hFFFF_FFF4};
        for (int k = 0; k < 4; k++) begin
            apply(insts[k], va[k], vb[k]);
            checks++;
            if (bus.result !== exp[k]) begin
                failures++;
                $display("FAIL other_add[%0d]: inst=%h got %h want %h", k, insts[k], bus.result, exp[k]);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3s   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic       exp_n [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       exp_e [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] i;
        for (int k = 0; k < 8; k++) begin
            i = 32'h0000_0063 | (32'(f3s[k]) << 12);
            apply(i, 32'hFFFF_FFFF, 32'd1);
            checks++;
            if (bus.take_b !== exp_n[k]) begin
                failures++;
                $display("FAIL branch_neg[%0d]: inst=%h got %b want %b", k, i, bus.take_b, exp_n[k]);
            end
            apply(i, 32'd3, 32'd3);
            checks++;
            if (bus.take_b !== exp_e[k]) begin
                failures++;
                $display("FAIL branch_eq[%0d]: inst=%h got %b want %b", k, i, bus.take_b, exp_e[k]);
            end
        end
        apply(32'h0000_0033, 32'd3, 32'd3);
        checks++;
        if (bus.take_b !== 1'b0) begin
            failures++;
            $display("FAIL branch_nonb: got %b want 0", bus.take_b);
        end
    endtask

    task automatic test_imm();
        logic [31:0] insts [16] = '{32'hFFF0_0093, 32'h8000_006F, 32'h1234_50B7, 32'h0000_0033,
                                    32'h1234_5097, 32'hFE00_0FA3, 32'h0200_0023, 32'h8000_0063,
                                    32'h0000_00E3, 32'h0010_006F, 32'h000F_F06F, 32'h8000_2003,
                                    32'h0010_0067, 32'h0010_0073, 32'hFFFF_FFB3, 32'hFFFF_FF0F};
        logic [31:0] exp   [16] = '{32'hFFFF_FFFF, 32'hFFF0_0000, 32'h1234_5000, 32'h0000_0000,
                                    32'h1234_5000, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_F000,
                                    32'h0000_0800, 32'h0000_0800, 32'h000F_F000, 32'hFFFF_F800,
                                    32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        for (int k = 0; k < 16; k++) begin
            apply(insts[k], 32'd0, 32'd0);
            checks++;
            if (bus.imm !== exp[k]) begin
                failures++;
                $display("FAIL imm[%0d]: inst=%h got %h want %h", k, insts[k], bus.imm, exp[k]);
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] exp_early;
        apply(32'h0000_0033, 32'd2, 32'd3);
        checks++;
        if (bus.result !== 32'd5) begin
            failures++;
            $display("FAIL add_2_3: got %h want 00000005", bus.result);
        end
        @(negedge clk);
        bus.in_a = 32'd10;
        bus.in_b = 32'd20;
        #1;
`ifdef ALU_OUTREG_EN
        exp_early = 32'd5;
`else
        exp_early = 32'd30;
`endif
        checks++;
        if (bus.result !== exp_early) begin
            failures++;
            $display("FAIL latency_pre_edge: got %h want %h", bus.result, exp_early);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.result !== 32'd30) begin
            failures++;
            $display("FAIL latency_post_edge: got %h want 0000001e", bus.result);
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [31:0] exp_rst;
`ifdef ALU_OUTREG_EN
        exp_rst = 32'd0;
`else
        exp_rst = 32'd5;
`endif
        reset = 1'b1;
        apply(32'h0000_0033, 32'd2, 32'd3);
        checks++;
        if (bus.result !== exp_rst) begin
            failures++;
            $display("FAIL reset_over_add: got %h want %h", bus.result, exp_rst);
        end
        reset = 1'b0;
        apply(32'h0000_0033, 32'd2, 32'd3);
        checks++;
        if (bus.result !== 32'd5) begin
            failures++;
            $display("FAIL add_after_reset: got %h want 00000005", bus.result);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.inst = '0;
        bus.in_a = '0;
        bus.in_b = '0;
        test_reset();
        test_r_type();
        test_op_imm();
        test_other_add();
        test_branch();
        test_imm();
        test_latency();
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
